// File: rtl/ltl_stage_pkg.sv
// Shared constants, record type and width helper for the LTL monitor stage.
package ltl_stage_pkg;

  localparam int DEF_NUM_CH         = 4;
  localparam int DEF_REPORTS_PER_CH = 4;
  localparam int DEF_SYM_W          = 8;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_IDX_W          = 32;

  // Index width for a field selecting one of n items; never narrower than 1 bit
  // so single-channel / single-report builds still get a legal port.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEF_CH_W  = clog2_min1(DEF_NUM_CH);
  localparam int DEF_REP_W = clog2_min1(DEF_REPORTS_PER_CH);

  // Violation record at default widths, as seen by the stage wrapper.
  typedef struct packed {
    logic [DEF_CH_W-1:0]  ch;
    logic [DEF_REP_W-1:0] rep;
    logic [DEF_IDX_W-1:0] idx;
  } evt_rec_t;

endpackage

// File: rtl/ltl_report_collector.sv
// Qualifies automata reports, keeps sticky flags and per-channel hit counters,
// and holds a single-entry first-pending violation record with handshake.
module ltl_report_collector
  import ltl_stage_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int REPORTS_PER_CH = DEF_REPORTS_PER_CH,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int IDX_W          = DEF_IDX_W,
  localparam int NUM_REP = NUM_CH * REPORTS_PER_CH,
  localparam int CH_W    = clog2_min1(NUM_CH),
  localparam int REP_W   = clog2_min1(REPORTS_PER_CH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic [IDX_W-1:0]        cur_idx,
  input  logic [NUM_REP-1:0]      report_in,
  input  logic                    clr,
  output logic [NUM_REP-1:0]      report_sticky,
  output logic [NUM_CH*CNT_W-1:0] hit_cnt,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [CH_W-1:0]         evt_ch,
  output logic [REP_W-1:0]        evt_rep,
  output logic [IDX_W-1:0]        evt_idx,
  output logic                    evt_drop
);

  logic                    run_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_REP-1:0]      hits;
  logic                    any_hit;
  logic                    load;
  logic                    drop_now;
  int                      cand;
  logic [NUM_CH-1:0]       ch_hit;
  logic [CNT_W-1:0]        cnt_base;
  logic [NUM_CH*CNT_W-1:0] cnt_nxt;

  // Qualify reports with the delayed run and pick the lowest set flat index.
  always_comb begin
    hits    = report_in & {NUM_REP{run_q}};
    any_hit = |hits;
    cand    = 0;
    for (int i = NUM_REP - 1; i >= 0; i--) begin
      if (hits[i]) cand = i;
    end
    load     = any_hit && (!evt_valid || evt_ready);
    drop_now = any_hit && evt_valid && !evt_ready;
  end

  // Per-channel hit detect and saturating counter next value (clr applied first).
  always_comb begin
    ch_hit   = '0;
    cnt_base = '0;
    cnt_nxt  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_hit[c] = |hits[c*REPORTS_PER_CH +: REPORTS_PER_CH];
      cnt_base  = clr ? '0 : hit_cnt[c*CNT_W +: CNT_W];
      cnt_nxt[c*CNT_W +: CNT_W] = (ch_hit[c] && !(&cnt_base)) ? cnt_base + CNT_W'(1) : cnt_base;
    end
  end

  // Register run and the index of the symbol the automata are now evaluating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q <= 1'b0;
      idx_q <= '0;
    end else begin
      run_q <= run;
      if (run) idx_q <= cur_idx;
    end
  end

  // Sticky flags, counters and drop flag; a hit in the clr cycle survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      report_sticky <= '0;
      hit_cnt       <= '0;
      evt_drop      <= 1'b0;
    end else begin
      report_sticky <= (clr ? '0 : report_sticky) | hits;
      hit_cnt       <= cnt_nxt;
      evt_drop      <= (evt_drop && !clr) || drop_now;
    end
  end

  // Single-entry record: load on free slot or same-cycle accept, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_rep   <= '0;
      evt_idx   <= '0;
    end else if (load) begin
      evt_valid <= 1'b1;
      evt_ch    <= CH_W'(cand / REPORTS_PER_CH);
      evt_rep   <= REP_W'(cand % REPORTS_PER_CH);
      evt_idx   <= idx_q;
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ltl_stage_ctrl.sv
// Monitor-chain stage control: forwards the symbol stream, tracks the symbol
// index and hands automata reports to the collector.
module ltl_stage_ctrl
  import ltl_stage_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int REPORTS_PER_CH = DEF_REPORTS_PER_CH,
  parameter int SYM_W          = DEF_SYM_W,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int IDX_W          = DEF_IDX_W,
  localparam int NUM_REP = NUM_CH * REPORTS_PER_CH,
  localparam int CH_W    = clog2_min1(NUM_CH),
  localparam int REP_W   = clog2_min1(REPORTS_PER_CH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic                    sym_reset,
  input  logic [SYM_W-1:0]        in_symbols,
  output logic [SYM_W-1:0]        out_symbols,
  output logic                    out_reset,
  input  logic [NUM_REP-1:0]      report_in,
  input  logic                    clr,
  output logic [NUM_REP-1:0]      report_sticky,
  output logic [NUM_CH*CNT_W-1:0] hit_cnt,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [CH_W-1:0]         evt_ch,
  output logic [REP_W-1:0]        evt_rep,
  output logic [IDX_W-1:0]        evt_idx,
  output logic                    evt_drop
);

  logic [IDX_W-1:0] sym_cnt;
  logic [IDX_W-1:0] cur_idx;

  // A stream reset travelling with the symbol restarts its index at zero.
  assign cur_idx = sym_reset ? '0 : sym_cnt;

  // Forward symbol and stream reset, and advance the index, only when run is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_symbols <= '0;
      out_reset   <= 1'b0;
      sym_cnt     <= '0;
    end else if (run) begin
      out_symbols <= in_symbols;
      out_reset   <= sym_reset;
      sym_cnt     <= cur_idx + IDX_W'(1);
    end
  end

  ltl_report_collector #(
    .NUM_CH         (NUM_CH),
    .REPORTS_PER_CH (REPORTS_PER_CH),
    .CNT_W          (CNT_W),
    .IDX_W          (IDX_W)
  ) u_collector (
    .clk           (clk),
    .reset_n       (reset_n),
    .run           (run),
    .cur_idx       (cur_idx),
    .report_in     (report_in),
    .clr           (clr),
    .report_sticky (report_sticky),
    .hit_cnt       (hit_cnt),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_ch        (evt_ch),
    .evt_rep       (evt_rep),
    .evt_idx       (evt_idx),
    .evt_drop      (evt_drop)
  );

endmodule

// File: tb/tb_ltl_stage_ctrl.sv
// Bench for ltl_stage_ctrl: a default-width instance and a narrow instance
// (CNT_W=2, IDX_W=3) share stimulus and are compared to one reference model.
module tb_ltl_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        sym_reset = 1'b0;
  logic        clr = 1'b0;
  logic        evt_ready = 1'b0;
  logic [7:0]  in_symbols = '0;
  logic [15:0] report_in = '0;

  logic [7:0]  a_out_symbols, b_out_symbols;
  logic        a_out_reset, b_out_reset;
  logic [15:0] a_sticky, b_sticky;
  logic [63:0] a_hit_cnt;
  logic [7:0]  b_hit_cnt;
  logic        a_evt_valid, b_evt_valid;
  logic [1:0]  a_evt_ch, b_evt_ch, a_evt_rep, b_evt_rep;
  logic [31:0] a_evt_idx;
  logic [2:0]  b_evt_idx;
  logic        a_evt_drop, b_evt_drop;

  int n_vec = 0;
  int n_err = 0;

  // reference model state (unbounded counts and indices, reduced at compare time)
  logic [7:0]  m_sym;
  logic        m_rst;
  longint      m_seq;
  logic        m_run_q;
  longint      m_idx_q;
  logic [15:0] m_sticky;
  longint      m_cnt [4];
  logic        m_valid;
  int          m_flat;
  longint      m_idx;
  logic        m_drop;

  always #5 clk = ~clk;

  ltl_stage_ctrl dut_a (
    .clk(clk), .reset_n(reset_n), .run(run), .sym_reset(sym_reset),
    .in_symbols(in_symbols), .out_symbols(a_out_symbols), .out_reset(a_out_reset),
    .report_in(report_in), .clr(clr), .report_sticky(a_sticky), .hit_cnt(a_hit_cnt),
    .evt_valid(a_evt_valid), .evt_ready(evt_ready), .evt_ch(a_evt_ch),
    .evt_rep(a_evt_rep), .evt_idx(a_evt_idx), .evt_drop(a_evt_drop)
  );

  ltl_stage_ctrl #(.CNT_W(2), .IDX_W(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .run(run), .sym_reset(sym_reset),
    .in_symbols(in_symbols), .out_symbols(b_out_symbols), .out_reset(b_out_reset),
    .report_in(report_in), .clr(clr), .report_sticky(b_sticky), .hit_cnt(b_hit_cnt),
    .evt_valid(b_evt_valid), .evt_ready(evt_ready), .evt_ch(b_evt_ch),
    .evt_rep(b_evt_rep), .evt_idx(b_evt_idx), .evt_drop(b_evt_drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_sym = '0; m_rst = 1'b0; m_seq = 0; m_run_q = 1'b0; m_idx_q = 0;
    m_sticky = '0; m_valid = 1'b0; m_flat = 0; m_idx = 0; m_drop = 1'b0;
    for (int c = 0; c < 4; c++) m_cnt[c] = 0;
  endtask

  task automatic check_all();
    chk("a_sym", 64'(a_out_symbols), 64'(m_sym));
    chk("b_sym", 64'(b_out_symbols), 64'(m_sym));
    chk("a_orst", 64'(a_out_reset), 64'(m_rst));
    chk("b_orst", 64'(b_out_reset), 64'(m_rst));
    chk("a_sticky", 64'(a_sticky), 64'(m_sticky));
    chk("b_sticky", 64'(b_sticky), 64'(m_sticky));
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("a_cnt%0d", c), 64'(a_hit_cnt[c*16 +: 16]), 64'(sat(m_cnt[c], 65535)));
      chk($sformatf("b_cnt%0d", c), 64'(b_hit_cnt[c*2 +: 2]), 64'(sat(m_cnt[c], 3)));
    end
    chk("a_valid", 64'(a_evt_valid), 64'(m_valid));
    chk("b_valid", 64'(b_evt_valid), 64'(m_valid));
    chk("a_ch", 64'(a_evt_ch), 64'(m_flat / 4));
    chk("b_ch", 64'(b_evt_ch), 64'(m_flat / 4));
    chk("a_rep", 64'(a_evt_rep), 64'(m_flat % 4));
    chk("b_rep", 64'(b_evt_rep), 64'(m_flat % 4));
    chk("a_idx", 64'(a_evt_idx), 64'(m_idx % 64'h1_0000_0000));
    chk("b_idx", 64'(b_evt_idx), 64'(m_idx % 8));
    chk("a_drop", 64'(a_evt_drop), 64'(m_drop));
    chk("b_drop", 64'(b_evt_drop), 64'(m_drop));
  endtask

  // One clock: model the effect of the currently driven inputs, then compare.
  task automatic tick();
    logic [15:0] hits;
    longint cur;
    int low;
    logic drop_now;
    hits = m_run_q ? report_in : 16'h0;
    cur = sym_reset ? 0 : m_seq;
    drop_now = 1'b0;
    @(posedge clk);
    #1;
    if (hits != 16'h0) begin
      if (!m_valid || evt_ready) begin
        low = 0;
        while (!hits[low]) low++;
        m_valid = 1'b1; m_flat = low; m_idx = m_idx_q;
      end else begin
        drop_now = 1'b1;
      end
    end else if (m_valid && evt_ready) begin
      m_valid = 1'b0;
    end
    m_drop = (clr ? 1'b0 : m_drop) | drop_now;
    m_sticky = (clr ? 16'h0 : m_sticky) | hits;
    for (int c = 0; c < 4; c++)
      m_cnt[c] = (clr ? 0 : m_cnt[c]) + (((hits >> (c*4)) & 16'hF) != 16'h0 ? 1 : 0);
    if (run) begin
      m_sym = in_symbols; m_rst = sym_reset; m_seq = cur + 1;
    end
    m_idx_q = cur;
    m_run_q = run;
    check_all();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    chk("rst_valid", 64'(a_evt_valid), 64'd0);
    reset_n = 1'b1;

    // forwarding, then run low holds
    run = 1'b1; in_symbols = 8'h11; sym_reset = 1'b1; tick();
    chk("fwd_11", 64'(a_out_symbols), 64'h11);
    chk("fwd_rst1", 64'(a_out_reset), 64'd1);
    in_symbols = 8'h22; sym_reset = 1'b0; tick();
    chk("fwd_22", 64'(a_out_symbols), 64'h22);
    run = 1'b0; sym_reset = 1'b1; in_symbols = 8'h33;
    repeat (3) tick();
    chk("fwd_hold", 64'(a_out_symbols), 64'h22);
    chk("fwd_rst_hold", 64'(a_out_reset), 64'd0);
    sym_reset = 1'b0;

    // single hit on flat bit 9 for symbol index 5 (indices so far: 0, 1)
    run = 1'b1;
    repeat (4) begin in_symbols = 8'($urandom); tick(); end
    report_in = 16'h0200; evt_ready = 1'b0; tick();
    chk("hit_valid", 64'(a_evt_valid), 64'd1);
    chk("hit_ch", 64'(a_evt_ch), 64'd2);
    chk("hit_rep", 64'(a_evt_rep), 64'd1);
    chk("hit_idx", 64'(a_evt_idx), 64'd5);
    chk("hit_sticky9", 64'(a_sticky[9]), 64'd1);
    chk("hit_cnt2", 64'(a_hit_cnt[47:32]), 64'd1);
    report_in = 16'h0; evt_ready = 1'b1; tick();

    // simultaneous hits on bits 6 and 3
    report_in = 16'h0048; tick();
    chk("sim_ch", 64'(a_evt_ch), 64'd0);
    chk("sim_rep", 64'(a_evt_rep), 64'd3);
    chk("sim_sticky", 64'(a_sticky & 16'h0048), 64'h0048);
    chk("sim_cnt0", 64'(a_hit_cnt[15:0]), 64'd1);
    chk("sim_cnt1", 64'(a_hit_cnt[31:16]), 64'd1);
    chk("sim_drop", 64'(a_evt_drop), 64'd0);

    // backpressure and drop
    report_in = 16'h0; tick();
    evt_ready = 1'b0; report_in = 16'h0020; tick();
    report_in = 16'h1000; tick();
    chk("bp_drop", 64'(a_evt_drop), 64'd1);
    chk("bp_ch", 64'(a_evt_ch), 64'd1);
    chk("bp_rep", 64'(a_evt_rep), 64'd1);
    report_in = 16'h0; evt_ready = 1'b1; tick();
    chk("bp_acc", 64'(a_evt_valid), 64'd0);
    report_in = 16'h4000; evt_ready = 1'b0; tick();
    chk("bp3_ch", 64'(a_evt_ch), 64'd3);
    chk("bp3_rep", 64'(a_evt_rep), 64'd2);
    clr = 1'b1; report_in = 16'h0001; evt_ready = 1'b1; tick();
    chk("clr_sticky", 64'(a_sticky), 64'h0001);
    chk("clr_cnt0", 64'(a_hit_cnt[15:0]), 64'd1);
    chk("clr_cnt3", 64'(a_hit_cnt[63:48]), 64'd0);
    chk("clr_drop", 64'(a_evt_drop), 64'd0);

    // saturation
    report_in = 16'h0; tick();
    clr = 1'b0; report_in = 16'h0001;
    repeat (5) tick();
    chk("sat_b", 64'(b_hit_cnt[1:0]), 64'd3);
    chk("sat_a", 64'(a_hit_cnt[15:0]), 64'd5);

    // index wrap: 9 symbols from a stream reset, 9th has index 8
    report_in = 16'h0; sym_reset = 1'b1; tick();
    sym_reset = 1'b0;
    repeat (8) tick();
    run = 1'b0; report_in = 16'h0001; tick();
    chk("wrap_b", 64'(b_evt_idx), 64'd0);
    chk("wrap_a", 64'(a_evt_idx), 64'd8);
    run = 1'b1; sym_reset = 1'b1; report_in = 16'h0; tick();
    run = 1'b0; sym_reset = 1'b0; report_in = 16'h0004; tick();
    chk("srst_idx", 64'(a_evt_idx), 64'd0);
    chk("srst_rep", 64'(a_evt_rep), 64'd2);

    // async reset with a pending record
    run = 1'b1; report_in = 16'h0; tick();
    report_in = 16'h0080; evt_ready = 1'b0; tick();
    chk("pend_valid", 64'(a_evt_valid), 64'd1);
    report_in = 16'h0;
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 64'(a_evt_valid), 64'd0);
    check_all();
    #2 reset_n = 1'b1;
    evt_ready = 1'b1; run = 1'b1; tick();
    report_in = 16'h0100; tick();
    chk("post_idx", 64'(a_evt_idx), 64'd0);
    chk("post_ch", 64'(a_evt_ch), 64'd2);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      run        = ($urandom_range(0, 3) != 0);
      sym_reset  = ($urandom_range(0, 15) == 0);
      clr        = ($urandom_range(0, 31) == 0);
      evt_ready  = $urandom_range(0, 1) == 1;
      in_symbols = 8'($urandom);
      report_in  = 16'($urandom & $urandom & $urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
